hazard_ctrl: RTL

- Pipeline control unit that produces the stall/bubble inputs consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register.
- Tracks in-flight destination registers in an internal 3-entry scoreboard covering the EX, MEM and WB slots.
- Stalls ID on read-after-write hazards; there is no forwarding.
- Flushes wrong-path instructions on a taken branch (resolved in MEM) or a jump (resolved in EX).

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_scoreboard.sv | 44 ++++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package hazard_pkg;

    // Register 0 is hard-wired to zero, so it never carries a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One in-flight destination register tracked by the scoreboard.
    typedef struct packed {
        logic       valid;
        logic [4:0] wreg;
    } sb_entry_t;

    // Controller FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_STALL = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

    // Entry for the instruction leaving ID: a bubble or an r0 write is invisible.
    function automatic sb_entry_t make_entry(input logic wr_en,
                                             input logic [4:0] wreg,
                                             input logic kill);
        sb_entry_t e;
        e.valid = wr_en && (wreg != REG_ZERO) && !kill;
        e.wreg  = wreg;
        return e;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker for the EX, MEM and WB slots, with rs/rt match.
// Latency: shifts one slot per cycle; match outputs are combinational.
// Backpressure: none; the shift never stops, stalls are expressed as invalid pushes.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int SB_DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  sb_entry_t  push,
    input  logic       kill_mem,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    output logic       rs_match,
    output logic       rt_match
);

    // sb[0] = EX, sb[1] = MEM, sb[2] = WB
    sb_entry_t [SB_DEPTH-1:0] sb;

    // Advance every slot each cycle; a taken branch discards the instruction moving EX->MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb <= '0;
        end else begin
            sb <= {sb[SB_DEPTH-2:0], push};
            if (kill_mem) begin
                sb[1] <= '0;
            end
        end
    end

    // Any valid slot matching a nonzero source register is a conflict (WB writes at the edge).
    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb[i].valid && (sb[i].wreg == rs) && (rs != REG_ZERO)) rs_match = 1'b1;
            if (sb[i].valid && (sb[i].wreg == rt) && (rt != REG_ZERO)) rt_match = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls from a scoreboard, flushes for jumps and taken branches.
// Latency: stall/bubble outputs are combinational; scoreboard, FSM and counters update at the edge.
// Backpressure: a RAW hazard holds PC and IF/ID and injects an ID/EX bubble until the producer retires.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int SB_DEPTH = 3,
    parameter int CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       id_Rs,
    input  logic [4:0]       id_Rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_RegWr,
    input  logic [4:0]       id_wreg,
    input  logic             ex_Jump,
    input  logic             mem_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_bubble,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic      rs_match;
    logic      rt_match;
    logic      raw;
    logic      raw_eff;
    state_t    state;
    state_t    state_nxt;
    sb_entry_t push;

    // The instruction leaving ID enters EX unless it was replaced by a bubble.
    assign push = make_entry(id_RegWr, id_wreg, id_ex_bubble);

    hazard_scoreboard #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk      (Clk),
        .reset    (Reset),
        .push     (push),
        .kill_mem (mem_taken),
        .rs       (id_Rs),
        .rt       (id_Rt),
        .rs_match (rs_match),
        .rt_match (rt_match)
    );

    assign raw     = (id_uses_rs && rs_match) || (id_uses_rt && rt_match);
    // In FLUSH, ID holds a bubble, so whatever is on its fields is not a real reader.
    assign raw_eff = raw && (state != ST_FLUSH);

    // ID/EX is never held: stalls always resolve by bubbling ID/EX instead.
    assign id_ex_stall = 1'b0;

    // Prioritised pipeline control: taken branch, then jump, then RAW stall.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_bubble  = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if (!Reset) begin
            if (mem_taken) begin
                if_id_bubble  = 1'b1;
                id_ex_bubble  = 1'b1;
                ex_mem_bubble = 1'b1;
            end else if (ex_Jump) begin
                if_id_bubble  = 1'b1;
                id_ex_bubble  = 1'b1;
            end else if (raw_eff) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_bubble  = 1'b1;
            end
        end
    end

    // Next-state logic: any flush overrides a stall; FLUSH lasts one cycle unless re-branched.
    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN, ST_STALL: begin
                if (mem_taken || ex_Jump) state_nxt = ST_FLUSH;
                else if (raw)             state_nxt = ST_STALL;
                else                      state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
                state_nxt = mem_taken ? ST_FLUSH : ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State register and free-running performance counters (wrap naturally).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pc_stall)               stall_cnt <= stall_cnt + CNT_ONE;
            if (mem_taken || ex_Jump)   flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule
